cbf_spectrum_scheduler: RTL and testbench

- Sequences the per-angle power outputs of the CBF spectrum estimator onto one shared output AXI-Stream.
- Waits until every steering-angle lane has a valid power word, then captures all lanes in one cycle.
- Emits the captured words one per beat in ascending angle index, with tlast on the last angle.
- Tracks the argmax angle of each frame and reports it after the frame ends, ready for the downstream DoA/peak logic or the UART/DMA packetiser.

---
 rtl/cbf_pkg.sv | 37 +++
 rtl/cbf_argmax_tracker.sv | 50 +++++
 rtl/cbf_spectrum_scheduler.sv | 136 +++++++++++++
 tb/tb_cbf_spectrum_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbf_pkg.sv
// ----------------------------------------------------------------------------
// cbf_pkg
// Constants and types shared by the CBF spectrum output scheduler.
//   WORD_LENGTH_POWER  : width of one beamformer power word, derived from the
//                        I/Q sample width and the moving-average growth bits.
//   PHI_SCAN_NUM_STEPS : number of steering angles in the scan.
//   index_width()      : bits needed to address PHI_SCAN_NUM_STEPS angles.
//   sched_state_t      : IDLE/EMIT state encoding of the scheduler.
// ----------------------------------------------------------------------------
package cbf_pkg;

   localparam int WORD_LENGTH_I_AND_Q           = 16;
   localparam int MOVING_AVERAGE_SNAPSHOT_COUNT = 8;
   // |I+jQ|^2 of a complex product, plus accumulation growth.
   localparam int WORD_LENGTH_POWER =
      (2 * WORD_LENGTH_I_AND_Q + 8) * 2 + MOVING_AVERAGE_SNAPSHOT_COUNT;

   // Steering scan from -25 deg to +25 deg in 1 deg steps.
   localparam int PHI_SCAN_MIN_DEG   = -25;
   localparam int PHI_SCAN_MAX_DEG   = 25;
   localparam int PHI_SCAN_STEP_DEG  = 1;
   localparam int PHI_SCAN_NUM_STEPS =
      (PHI_SCAN_MAX_DEG - PHI_SCAN_MIN_DEG) / PHI_SCAN_STEP_DEG + 1;

   // Index width for n angles; never narrower than one bit.
   function automatic int index_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int INDEX_WIDTH = index_width(PHI_SCAN_NUM_STEPS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } sched_state_t;

endpackage

// File: rtl/cbf_argmax_tracker.sv
// ----------------------------------------------------------------------------
// cbf_argmax_tracker
// Running max/argmax over a stream of (index, value) candidates.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : forget the running max; the next update seeds it
//   update        : a candidate is presented this cycle
//   cand_index    : index of the candidate
//   cand_value    : unsigned value of the candidate
//   winner_index  : argmax including the current candidate (combinational)
//   winner_value  : max including the current candidate (combinational)
// A candidate replaces the running max only if strictly greater, so ties keep
// the earliest (lowest) index.
// ----------------------------------------------------------------------------
module cbf_argmax_tracker #(
   parameter int W  = cbf_pkg::WORD_LENGTH_POWER,
   parameter int IW = cbf_pkg::INDEX_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          update,
   input  logic [IW-1:0] cand_index,
   input  logic [W-1:0]  cand_value,
   output logic [IW-1:0] winner_index,
   output logic [W-1:0]  winner_value
);

   logic          seeded;
   logic [IW-1:0] best_index;
   logic [W-1:0]  best_value;
   logic          take;

   // The first candidate after a clear always seeds, whatever its value.
   assign take         = update && (!seeded || (cand_value > best_value));
   assign winner_index = take ? cand_index : best_index;
   assign winner_value = take ? cand_value : best_value;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         seeded     <= 1'b0;
         best_index <= '0;
         best_value <= '0;
      end else if (update) begin
         seeded     <= 1'b1;
         best_index <= winner_index;
         best_value <= winner_value;
      end
   end

endmodule

// File: rtl/cbf_spectrum_scheduler.sv
// ----------------------------------------------------------------------------
// cbf_spectrum_scheduler
// Collects one power word per steering angle, then streams them in ascending
// angle order on a single AXI-Stream and reports the frame's argmax.
//   clk, rst        : clock, synchronous active-high reset
//   s_axis_tdata    : N packed power words, lane i at [W*(i+1)-1 -: W]
//   s_axis_tvalid   : per-lane valid
//   s_axis_tready   : per-lane ready, all bits identical
//   m_axis_tdata    : power word of the current angle
//   m_axis_tvalid   : output valid
//   m_axis_tready   : downstream ready
//   m_axis_tlast    : last angle of the frame
//   m_axis_tuser    : angle index of the current beat
//   peak_index      : argmax angle of the last completed frame
//   peak_value      : power at peak_index
//   peak_valid      : one-cycle pulse when peak_index/peak_value update
//   frame_count     : completed frames, wraps modulo 2^16
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; valid never depends on ready, and while valid is high and ready
// low the payload (tdata/tuser/tlast) is held unchanged.
// ----------------------------------------------------------------------------
module cbf_spectrum_scheduler #(
   parameter int PHI_SCAN_NUM_STEPS = cbf_pkg::PHI_SCAN_NUM_STEPS,
   parameter int WORD_LENGTH_POWER  = cbf_pkg::WORD_LENGTH_POWER,
   parameter int INDEX_WIDTH        = cbf_pkg::INDEX_WIDTH
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [PHI_SCAN_NUM_STEPS*WORD_LENGTH_POWER-1:0] s_axis_tdata,
   input  logic [PHI_SCAN_NUM_STEPS-1:0]               s_axis_tvalid,
   output logic [PHI_SCAN_NUM_STEPS-1:0]               s_axis_tready,
   output logic [WORD_LENGTH_POWER-1:0]                m_axis_tdata,
   output logic                                        m_axis_tvalid,
   input  logic                                        m_axis_tready,
   output logic                                        m_axis_tlast,
   output logic [INDEX_WIDTH-1:0]                      m_axis_tuser,
   output logic [INDEX_WIDTH-1:0]                      peak_index,
   output logic [WORD_LENGTH_POWER-1:0]                peak_value,
   output logic                                        peak_valid,
   output logic [15:0]                                 frame_count
);

   import cbf_pkg::*;

   localparam int N  = PHI_SCAN_NUM_STEPS;
   localparam int W  = WORD_LENGTH_POWER;
   localparam int IW = INDEX_WIDTH;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   sched_state_t  state;
   logic [IW-1:0] idx;
   logic [W-1:0]  bank [N];
   logic [15:0]   frame_cnt_q;

   logic          emit;
   logic          capture;
   logic          beat;
   logic [W-1:0]  cur_word;
   logic [IW-1:0] winner_index;
   logic [W-1:0]  winner_value;

   assign emit     = (state == ST_EMIT);
   // All lanes handshake together or not at all, so skewed estimators simply
   // keep their word until the slowest lane catches up.
   assign capture  = (state == ST_IDLE) && (&s_axis_tvalid) && !rst;
   assign beat     = emit && m_axis_tready;
   assign cur_word = bank[idx];

   assign s_axis_tready = {N{capture}};
   assign m_axis_tvalid = emit;
   assign m_axis_tdata  = emit ? cur_word : '0;
   assign m_axis_tuser  = emit ? idx : '0;
   assign m_axis_tlast  = emit && (idx == LAST_IDX);
   assign frame_count   = frame_cnt_q;

   // Data bank needs no reset: it is only observed in EMIT, after a capture.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < N; i++) begin
            bank[i] <= s_axis_tdata[W*(i+1)-1 -: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         peak_index  <= '0;
         peak_value  <= '0;
         peak_valid  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         peak_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (capture) begin
                  state <= ST_EMIT;
                  idx   <= '0;
               end
            end
            ST_EMIT: begin
               if (beat) begin
                  if (idx == LAST_IDX) begin
                     // winner_* already folds in the last beat's word.
                     state       <= ST_IDLE;
                     idx         <= '0;
                     peak_index  <= winner_index;
                     peak_value  <= winner_value;
                     peak_valid  <= 1'b1;
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   cbf_argmax_tracker #(
      .W  (W),
      .IW (IW)
   ) u_argmax (
      .clk          (clk),
      .rst          (rst),
      .clear        (capture),
      .update       (beat),
      .cand_index   (idx),
      .cand_value   (cur_word),
      .winner_index (winner_index),
      .winner_value (winner_value)
   );

endmodule

// File: tb/tb_cbf_spectrum_scheduler.sv
`timescale 1ns/1ps

module tb_cbf_spectrum_scheduler;

  localparam int N  = 51;
  localparam int W  = 88;
  localparam int IW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic [N*W-1:0] s_axis_tdata;
  logic [N-1:0]   s_axis_tvalid;
  logic [N-1:0]   s_axis_tready;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic [IW-1:0]  m_axis_tuser;
  logic [IW-1:0]  peak_index;
  logic [W-1:0]   peak_value;
  logic           peak_valid;
  logic [15:0]    frame_count;

  logic [W-1:0] lane_val [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign s_axis_tdata[W*(g+1)-1 -: W] = lane_val[g];
  end

  cbf_spectrum_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .peak_index    (peak_index),
    .peak_value    (peak_value),
    .peak_valid    (peak_valid),
    .frame_count   (frame_count)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] exp_user_q[$];
  logic [IW-1:0] exp_pidx_q[$];
  logic [W-1:0]  exp_pval_q[$];
  logic [15:0]   exp_pfc_q[$];
  logic [15:0]   exp_fc;
  int            frames_exp   = 0;
  int            peak_pulses  = 0;
  int            stall_cycles = 0;
  bit            stall_mode;
  int            cap_cyc;

  task automatic report_fail(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    failures++;
    $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference argmax: strict-greater scan, index 0 seeds.
  task automatic push_frame();
    logic [W-1:0]  best;
    logic [IW-1:0] bi;
    best = '0;
    bi   = '0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(lane_val[i]);
      exp_user_q.push_back(IW'(i));
      if (i == 0 || lane_val[i] > best) begin
        best = lane_val[i];
        bi   = IW'(i);
      end
    end
    exp_fc = exp_fc + 16'd1;
    exp_pidx_q.push_back(bi);
    exp_pval_q.push_back(best);
    exp_pfc_q.push_back(exp_fc);
    frames_exp++;
  endtask

  task automatic flush_frame();
    exp_q.delete();
    exp_user_q.delete();
    exp_pidx_q.delete();
    exp_pval_q.delete();
    exp_pfc_q.delete();
    frames_exp--;
    exp_fc = '0;
  endtask

  // ---------------- monitor ----------------
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic [IW-1:0] prev_user;
  logic          prev_last;
  logic [W-1:0]  ed;
  logic [IW-1:0] eu;
  logic [IW-1:0] ep_idx;
  logic [W-1:0]  ep_val;
  logic [15:0]   ep_fc;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1) report_fail("stall_valid", m_axis_tvalid, 1'b1);
        checks++;
        if (m_axis_tdata !== prev_data) report_fail("stall_data", m_axis_tdata, prev_data);
        checks++;
        if (m_axis_tuser !== prev_user) report_fail("stall_user", m_axis_tuser, prev_user);
        checks++;
        if (m_axis_tlast !== prev_last) report_fail("stall_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) report_fail("beat_pending", 0, 1);
        if (exp_q.size() > 0) begin
          ed = exp_q.pop_front();
          eu = exp_user_q.pop_front();
          checks++;
          if (m_axis_tuser !== eu) report_fail("beat_user", m_axis_tuser, eu);
          checks++;
          if (m_axis_tdata !== ed) report_fail("beat_data", m_axis_tdata, ed);
          checks++;
          if (m_axis_tlast !== (eu == IW'(N - 1)))
            report_fail("beat_last", m_axis_tlast, (eu == IW'(N - 1)));
        end
      end
      if (m_axis_tvalid && !m_axis_tready) stall_cycles++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;
      prev_last  = m_axis_tlast;
      if (peak_valid) begin
        peak_pulses++;
        checks++;
        if (exp_pidx_q.size() == 0) report_fail("peak_pending", 0, 1);
        if (exp_pidx_q.size() > 0) begin
          ep_idx = exp_pidx_q.pop_front();
          ep_val = exp_pval_q.pop_front();
          ep_fc  = exp_pfc_q.pop_front();
          checks++;
          if (peak_index !== ep_idx) report_fail("peak_index", peak_index, ep_idx);
          checks++;
          if (peak_value !== ep_val) report_fail("peak_value", peak_value, ep_val);
          checks++;
          if (frame_count !== ep_fc) report_fail("frame_count", frame_count, ep_fc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_tready();
    m_axis_tready = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_tready();
  endtask

  // Waits for the all-lane capture, pushes the frame's expectations.
  task automatic capture_frame(input int limit, input bit keep_valid);
    bit found;
    found = 1'b0;
    for (int c = 0; c < limit && !found; c++) begin
      @(negedge clk);
      if (s_axis_tready[0]) found = 1'b1;
      else step();
    end
    checks++;
    if (found !== 1'b1) report_fail("capture_seen", found, 1'b1);
    if (found) begin
      checks++;
      if (s_axis_tready !== {N{1'b1}}) report_fail("tready_all", s_axis_tready, {N{1'b1}});
      push_frame();
      cap_cyc = cyc;
      step();
      if (!keep_valid) s_axis_tvalid = '0;
    end
  endtask

  task automatic wait_done(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (exp_q.size() == 0 && exp_pidx_q.size() == 0) break;
      step();
    end
    checks++;
    if (exp_q.size() != 0 || exp_pidx_q.size() != 0)
      report_fail("frame_done", exp_q.size(), 0);
  endtask

  task automatic set_ramp(input int base);
    for (int i = 0; i < N; i++) lane_val[i] = W'(base + i);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int caps [4];
    bit found;
    rst           = 1'b1;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    stall_mode    = 1'b0;
    exp_fc        = '0;
    set_ramp(0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checks++;
    if (s_axis_tready !== {N{1'b0}}) report_fail("rst_s_tready", s_axis_tready, 0);
    checks++;
    if (m_axis_tvalid !== 1'b0) report_fail("rst_m_tvalid", m_axis_tvalid, 0);
    checks++;
    if (m_axis_tdata !== {W{1'b0}}) report_fail("rst_m_tdata", m_axis_tdata, 0);
    checks++;
    if (m_axis_tuser !== {IW{1'b0}}) report_fail("rst_m_tuser", m_axis_tuser, 0);
    checks++;
    if (m_axis_tlast !== 1'b0) report_fail("rst_m_tlast", m_axis_tlast, 0);
    checks++;
    if (peak_valid !== 1'b0) report_fail("rst_peak_valid", peak_valid, 0);
    checks++;
    if (frame_count !== 16'd0) report_fail("rst_frame_count", frame_count, 0);
    rst = 1'b0;
    step();

    // 1: ramp 100..150, tready always high
    set_ramp(100);
    s_axis_tvalid = '1;
    capture_frame(10, 1'b0);
    wait_done(100);
    step();
    checks++;
    if (peak_index !== IW'(50)) report_fail("t1_peak_index_hold", peak_index, 50);
    checks++;
    if (peak_value !== W'(150)) report_fail("t1_peak_value_hold", peak_value, 150);
    checks++;
    if (frame_count !== 16'd1) report_fail("t1_frame_count", frame_count, 1);
    checks++;
    if (peak_pulses != 1) report_fail("t1_peak_pulses", peak_pulses, 1);

    // 2: lane N-1 late by 20 cycles
    set_ramp(200);
    s_axis_tvalid = {1'b0, {(N-1){1'b1}}};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (s_axis_tready !== {N{1'b0}}) report_fail("t2_no_tready", s_axis_tready, 0);
      checks++;
      if (m_axis_tvalid !== 1'b0) report_fail("t2_no_output", m_axis_tvalid, 0);
      step();
    end
    s_axis_tvalid[N-1] = 1'b1;
    capture_frame(1, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b1) report_fail("t2_first_beat_valid", m_axis_tvalid, 1);
    checks++;
    if (m_axis_tuser !== {IW{1'b0}}) report_fail("t2_first_beat_user", m_axis_tuser, 0);
    wait_done(100);

    // 3: tie between lanes 7 and 30 keeps index 7; then a random frame
    for (int i = 0; i < N; i++) lane_val[i] = '0;
    lane_val[7]  = W'(1) << 87;
    lane_val[30] = W'(1) << 87;
    s_axis_tvalid = '1;
    capture_frame(10, 1'b0);
    wait_done(100);
    checks++;
    if (peak_index !== IW'(7)) report_fail("t3_tie_index", peak_index, 7);
    for (int i = 0; i < N; i++)
      lane_val[i] = W'({$urandom(), $urandom(), $urandom()});
    s_axis_tvalid = '1;
    capture_frame(10, 1'b0);
    wait_done(100);

    // 4: random backpressure on the ramp frame
    stall_cycles = 0;
    stall_mode   = 1'b1;
    set_ramp(100);
    s_axis_tvalid = '1;
    capture_frame(10, 1'b0);
    wait_done(600);
    stall_mode    = 1'b0;
    m_axis_tready = 1'b1;
    checks++;
    if (stall_cycles <= 0) report_fail("t4_stalls_seen", stall_cycles, 1);

    // 5: reset in the middle of a frame (beat 20)
    set_ramp(300);
    s_axis_tvalid = '1;
    capture_frame(10, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tuser == IW'(20)) found = 1'b1;
      else step();
    end
    checks++;
    if (found !== 1'b1) report_fail("t5_beat20_seen", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    flush_frame();
    checks++;
    if (m_axis_tvalid !== 1'b0) report_fail("t5_m_tvalid", m_axis_tvalid, 0);
    checks++;
    if (m_axis_tdata !== {W{1'b0}}) report_fail("t5_m_tdata", m_axis_tdata, 0);
    checks++;
    if (m_axis_tuser !== {IW{1'b0}}) report_fail("t5_m_tuser", m_axis_tuser, 0);
    checks++;
    if (m_axis_tlast !== 1'b0) report_fail("t5_m_tlast", m_axis_tlast, 0);
    checks++;
    if (peak_valid !== 1'b0) report_fail("t5_peak_valid", peak_valid, 0);
    checks++;
    if (peak_index !== {IW{1'b0}}) report_fail("t5_peak_index", peak_index, 0);
    checks++;
    if (peak_value !== {W{1'b0}}) report_fail("t5_peak_value", peak_value, 0);
    checks++;
    if (frame_count !== 16'd0) report_fail("t5_frame_count", frame_count, 0);
    checks++;
    if (s_axis_tready !== {N{1'b0}}) report_fail("t5_s_tready", s_axis_tready, 0);
    rst = 1'b0;
    step();
    checks++;
    if (peak_valid !== 1'b0) report_fail("t5_no_pulse_after", peak_valid, 0);
    set_ramp(400);
    s_axis_tvalid = '1;
    capture_frame(10, 1'b0);
    wait_done(100);
    checks++;
    if (frame_count !== 16'd1) report_fail("t5_frame_count_after", frame_count, 1);

    // 6: back-to-back frames through the frame_count wrap
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    exp_fc = 16'hFFFE;
    checks++;
    if (frame_count !== 16'hFFFE) report_fail("t6_preload", frame_count, 16'hFFFE);
    for (int i = 0; i < N; i++) lane_val[i] = W'((i * 37) % 53);
    s_axis_tvalid = '1;
    for (int f = 0; f < 4; f++) begin
      capture_frame(80, (f != 3));
      caps[f] = cap_cyc;
    end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (caps[f+1] - caps[f] != N + 1)
        report_fail("t6_period", caps[f+1] - caps[f], N + 1);
    end
    wait_done(100);
    checks++;
    if (frame_count !== 16'd2) report_fail("t6_frame_count_wrap", frame_count, 2);

    // Final accounting
    repeat (3) step();
    checks++;
    if (peak_pulses != frames_exp) report_fail("peak_pulse_total", peak_pulses, frames_exp);
    checks++;
    if (exp_q.size() != 0) report_fail("beats_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
